usb_rx_fifo: RTL and testbench
==============================

USB_RX_FIFO -- requirements
Module: usb_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 32, number of stored words; power of two, 4..256.
REQ-002 Parameter AFULL_MARGIN, default 4, ALMOST_FULL asserts when free slots <= AFULL_MARGIN.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 WR_EN  input  1  write strobe from USB front end; one word per asserted cycle.
REQ-006 WR_DATA  input  16  word read from FT bus.
REQ-007 WR_BE  input  2  byte enables accompanying WR_DATA.
REQ-008 FULL  output  1  no free slot.
REQ-009 ALMOST_FULL  output  1  backpressure to front end; front end stops new read cycles.
REQ-010 RD_DATA  output  16  head word, first-word-fall-through.
REQ-011 RD_BE  output  2  byte enables of head word.
REQ-012 RD_VALID  output  1  head word present.
REQ-013 RD_READY  input  1  consumer accepts head word.
REQ-014 LEVEL  output  log2(DEPTH)+1  stored word count, 0..DEPTH.
REQ-015 OVERFLOW  output  1  sticky: a write was dropped.
REQ-016 OVF_COUNT  output  8  dropped-write counter (see Configuration).

Function
REQ-017 Write accepted when WR_EN=1, WR_BE!=2'b00, FULL=0; stores {WR_BE,WR_DATA} at write pointer, pointer increments mod DEPTH.
REQ-018 WR_EN=1 with WR_BE=2'b00: word discarded silently; no pointer, LEVEL or OVERFLOW change.
REQ-019 WR_EN=1, WR_BE!=0, FULL=1: word dropped, OVERFLOW set; drop applies even if a read occurs same cycle.
REQ-020 Read occurs when RD_VALID=1 and RD_READY=1; read pointer increments mod DEPTH.
REQ-021 RD_VALID = (LEVEL!=0); RD_DATA/RD_BE show word at read pointer; don't-care when RD_VALID=0.
REQ-022 Latency: word accepted at edge N visible with RD_VALID=1 after edge N (combinational FWFT from storage), i.e. one cycle write-to-read.
REQ-023 LEVEL: +1 on accepted write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-024 Simultaneous write and read when LEVEL=DEPTH-1 or 1: both succeed, LEVEL unchanged, no glitch on FULL/RD_VALID.
REQ-025 FULL = (LEVEL==DEPTH); ALMOST_FULL = (LEVEL >= DEPTH-AFULL_MARGIN); both registered-consistent with LEVEL same cycle.
REQ-026 Pointers wrap DEPTH-1 -> 0 with no data loss or reordering; strict FIFO order.
REQ-027 RD_READY with RD_VALID=0 has no effect.

Reset
REQ-028 RST=1 at rising edge: pointers 0, LEVEL 0, FULL 0, ALMOST_FULL 0, RD_VALID 0, OVERFLOW 0, OVF_COUNT 0.
REQ-029 Reset mid-burst discards all stored words; WR_EN/RD_READY ignored while RST=1; storage contents not cleared.
REQ-030 First write accepted on the first edge with RST=0.

Configuration
REQ-031 Macro USB_RX_OVF_COUNT_EN defined: OVF_COUNT increments on each dropped write (REQ-019), saturates at 255, cleared only by reset.
REQ-032 Macro not defined: OVF_COUNT tied 8'd0, no counter logic; OVERFLOW unaffected; port list identical.

Verification
REQ-033 Reset, write 0x1234/BE=11, RD_READY=0 -> next cycle RD_VALID=1, RD_DATA=0x1234, RD_BE=11, LEVEL=1.
REQ-034 Write 32 words 0..31 without reads -> ALMOST_FULL at LEVEL=28, FULL at 32; 33rd write 0xFFFF -> dropped, OVERFLOW=1, OVF_COUNT=1 (macro on) / 0 (off); read out -> 0..31 in order.
REQ-035 Fill to 32, then WR_EN and RD_READY both high 1 cycle -> read word 0, new word dropped, LEVEL=31, OVERFLOW=1.
REQ-036 Continuous write+read for 100 cycles with LEVEL=1 -> LEVEL stays 1, pointers wrap thrice, output sequence matches input delayed one word.
REQ-037 Write with WR_BE=00 -> LEVEL unchanged, RD_VALID unchanged, OVERFLOW=0.
REQ-038 Write 10 words, assert RST one cycle mid-stream -> LEVEL=0, RD_VALID=0, OVERFLOW=0 next cycle; subsequent write 0xABCD read back first.

Source files
------------

// File: rtl/usb_rx_fifo.sv
// First-word-fall-through receive FIFO between the USB FT-bus front end and its consumer.
// Define USB_RX_OVF_COUNT_EN to build the saturating dropped-write counter behind OVF_COUNT.
module usb_rx_fifo #(
    parameter int DEPTH        = 32,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WR_EN,
    input  logic [15:0]              WR_DATA,
    input  logic [1:0]               WR_BE,
    output logic                     FULL,
    output logic                     ALMOST_FULL,
    output logic [15:0]              RD_DATA,
    output logic [1:0]               RD_BE,
    output logic                     RD_VALID,
    input  logic                     RD_READY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVERFLOW,
    output logic [7:0]               OVF_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_LEVEL = (AW+1)'(DEPTH - AFULL_MARGIN);

    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          overflow;

    logic write_req;
    logic wr_accept;
    logic wr_drop;
    logic rd_fire;
    logic full;

    // Fullness is judged on the level at the start of the cycle, so a write
    // arriving while full is dropped even if a read frees a slot that same edge.
    assign full      = (level == FULL_LEVEL);
    assign write_req = WR_EN && (WR_BE != 2'b00);
    assign wr_accept = write_req && !full;
    assign wr_drop   = write_req && full;
    assign rd_fire   = (level != '0) && RD_READY;

    always_ff @(posedge CLK) begin
        if (!RST && wr_accept) begin
            mem[wr_ptr] <= {WR_BE, WR_DATA};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_fire})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (wr_drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef USB_RX_OVF_COUNT_EN
    logic [7:0] ovf_count;

    // Saturates rather than wrapping so a long overrun never reads back as small.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_count <= 8'd0;
        end else if (wr_drop && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end

    assign OVF_COUNT = ovf_count;
`else
    assign OVF_COUNT = 8'd0;
`endif

    assign FULL        = full;
    assign ALMOST_FULL = (level >= AFULL_LEVEL);
    assign RD_VALID    = (level != '0);
    assign RD_DATA     = mem[rd_ptr][15:0];
    assign RD_BE       = mem[rd_ptr][17:16];
    assign LEVEL       = level;
    assign OVERFLOW    = overflow;

endmodule

// File: tb/tb_usb_rx_fifo.sv
// Directed self-checking bench for usb_rx_fifo at DEPTH=32, AFULL_MARGIN=4.
// Expected OVF_COUNT follows whether USB_RX_OVF_COUNT_EN is defined for the build.
module tb_usb_rx_fifo;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WR_EN = 1'b0;
    logic [15:0] WR_DATA = 16'h0000;
    logic [1:0]  WR_BE = 2'b00;
    logic        RD_READY = 1'b0;
    logic        FULL;
    logic        ALMOST_FULL;
    logic [15:0] RD_DATA;
    logic [1:0]  RD_BE;
    logic        RD_VALID;
    logic [5:0]  LEVEL;
    logic        OVERFLOW;
    logic [7:0]  OVF_COUNT;

    int checks = 0;
    int failures = 0;

`ifdef USB_RX_OVF_COUNT_EN
    localparam logic [7:0] OVF_ONE = 8'd1;
`else
    localparam logic [7:0] OVF_ONE = 8'd0;
`endif

    usb_rx_fifo #(.DEPTH(32), .AFULL_MARGIN(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .WR_EN       (WR_EN),
        .WR_DATA     (WR_DATA),
        .WR_BE       (WR_BE),
        .FULL        (FULL),
        .ALMOST_FULL (ALMOST_FULL),
        .RD_DATA     (RD_DATA),
        .RD_BE       (RD_BE),
        .RD_VALID    (RD_VALID),
        .RD_READY    (RD_READY),
        .LEVEL       (LEVEL),
        .OVERFLOW    (OVERFLOW),
        .OVF_COUNT   (OVF_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic rst, input logic wr_en, input logic [15:0] data,
                                 input logic [1:0] be, input logic rd_ready);
        RST      = rst;
        WR_EN    = wr_en;
        WR_DATA  = data;
        WR_BE    = be;
        RD_READY = rd_ready;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0);
        tick();
        tick();
        checkOutput("reset_level", 32'(LEVEL), 32'd0);
        checkOutput("reset_full", 32'(FULL), 32'd0);
        checkOutput("reset_afull", 32'(ALMOST_FULL), 32'd0);
        checkOutput("reset_valid", 32'(RD_VALID), 32'd0);
        checkOutput("reset_ovf", 32'(OVERFLOW), 32'd0);
        checkOutput("reset_ovf_count", 32'(OVF_COUNT), 32'd0);

        // First write lands on the first edge with reset released
        applyStimulus(1'b0, 1'b1, 16'h1234, 2'b11, 1'b0);
        tick();
        checkOutput("single_valid", 32'(RD_VALID), 32'd1);
        checkOutput("single_data", 32'(RD_DATA), 32'h1234);
        checkOutput("single_be", 32'(RD_BE), 32'd3);
        checkOutput("single_level", 32'(LEVEL), 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        tick();
        checkOutput("single_drain_level", 32'(LEVEL), 32'd0);
        checkOutput("single_drain_valid", 32'(RD_VALID), 32'd0);

        // Empty read attempt and zero byte-enable write are both no-ops
        applyStimulus(1'b0, 1'b1, 16'h5555, 2'b00, 1'b1);
        tick();
        checkOutput("be0_level", 32'(LEVEL), 32'd0);
        checkOutput("be0_valid", 32'(RD_VALID), 32'd0);
        checkOutput("be0_ovf", 32'(OVERFLOW), 32'd0);

        // Fill to 32 watching the almost-full and full thresholds
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(i), 2'b11, 1'b0);
            tick();
            checkOutput($sformatf("fill_level_%0d", i), 32'(LEVEL), 32'(i + 1));
            checkOutput($sformatf("fill_afull_%0d", i), 32'(ALMOST_FULL), 32'((i + 1) >= 28));
            checkOutput($sformatf("fill_full_%0d", i), 32'(FULL), 32'((i + 1) == 32));
        end
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 2'b11, 1'b0);
        tick();
        checkOutput("drop_level", 32'(LEVEL), 32'd32);
        checkOutput("drop_ovf", 32'(OVERFLOW), 32'd1);
        checkOutput("drop_ovf_count", 32'(OVF_COUNT), 32'(OVF_ONE));
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("drain_data_%0d", i), 32'(RD_DATA), 32'(i));
            checkOutput($sformatf("drain_be_%0d", i), 32'(RD_BE), 32'd3);
            tick();
        end
        checkOutput("drain_level", 32'(LEVEL), 32'd0);
        checkOutput("drain_valid", 32'(RD_VALID), 32'd0);
        checkOutput("drain_ovf_sticky", 32'(OVERFLOW), 32'd1);

        // Write and read together while full: read wins, write dropped
        applyStimulus(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0);
        tick();
        checkOutput("rst2_ovf", 32'(OVERFLOW), 32'd0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0100 + 16'(i), 2'b01, 1'b0);
            tick();
        end
        checkOutput("full2_full", 32'(FULL), 32'd1);
        applyStimulus(1'b0, 1'b1, 16'hEEEE, 2'b11, 1'b1);
        tick();
        checkOutput("fullrw_level", 32'(LEVEL), 32'd31);
        checkOutput("fullrw_ovf", 32'(OVERFLOW), 32'd1);
        checkOutput("fullrw_full", 32'(FULL), 32'd0);
        checkOutput("fullrw_ovf_count", 32'(OVF_COUNT), 32'(OVF_ONE));
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        for (int i = 1; i < 32; i++) begin
            checkOutput($sformatf("fullrw_data_%0d", i), 32'(RD_DATA), 32'h0100 + 32'(i));
            tick();
        end
        checkOutput("fullrw_empty", 32'(RD_VALID), 32'd0);

        // Reset mid-stream discards contents and clears the sticky flag
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0A00 + 16'(i), 2'b11, 1'b0);
            tick();
        end
        checkOutput("midrst_pre_level", 32'(LEVEL), 32'd10);
        applyStimulus(1'b1, 1'b1, 16'h0BAD, 2'b11, 1'b1);
        tick();
        checkOutput("midrst_level", 32'(LEVEL), 32'd0);
        checkOutput("midrst_valid", 32'(RD_VALID), 32'd0);
        checkOutput("midrst_ovf", 32'(OVERFLOW), 32'd0);
        checkOutput("midrst_ovf_count", 32'(OVF_COUNT), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'hABCD, 2'b11, 1'b0);
        tick();
        checkOutput("midrst_first_data", 32'(RD_DATA), 32'hABCD);
        checkOutput("midrst_first_level", 32'(LEVEL), 32'd1);

        // Streaming at level 1 for 100 cycles wraps the pointers three times
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b0, 1'b1, 16'h5000 + 16'(k), 2'(k % 3 + 1), 1'b1);
            if (k == 0) begin
                checkOutput("stream_data_0", 32'(RD_DATA), 32'hABCD);
                checkOutput("stream_be_0", 32'(RD_BE), 32'd3);
            end else begin
                checkOutput($sformatf("stream_data_%0d", k), 32'(RD_DATA), 32'h5000 + 32'(k - 1));
                checkOutput($sformatf("stream_be_%0d", k), 32'(RD_BE), 32'((k - 1) % 3 + 1));
            end
            tick();
            checkOutput($sformatf("stream_level_%0d", k), 32'(LEVEL), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        checkOutput("stream_last_data", 32'(RD_DATA), 32'h5063);
        checkOutput("stream_last_be", 32'(RD_BE), 32'd1);
        tick();
        checkOutput("stream_end_level", 32'(LEVEL), 32'd0);
        checkOutput("stream_end_ovf", 32'(OVERFLOW), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
